// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - shared FSM encoding, IO address map and address decode helper
package tron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [15:0] IO_LED_ADDR = 16'hC000;
    localparam logic [15:0] IO_SW_ADDR  = 16'hC001;
    localparam logic [1:0]  IO_REGION   = 2'b11;
    localparam int          LED_BITS    = 10;

    function automatic logic is_io_addr(input logic [15:0] addr);
        return addr[15:14] == IO_REGION;
    endfunction

endpackage

// File: rtl/io_regs.sv
// rtl/io_regs.sv - LED register and IO read mux (switches are read-only)
module io_regs
    import tron_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                led_we_i,
    input  logic [LED_BITS-1:0] led_wdata_i,
    input  logic [WIDTH-1:0]    rd_addr_i,
    input  logic [LED_BITS-1:0] io_sw_i,
    output logic [LED_BITS-1:0] io_led_o,
    output logic [WIDTH-1:0]    rd_data_o
);

    logic [LED_BITS-1:0] led_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else if (led_we_i) begin
            led_q <= led_wdata_i;
        end
    end

    // Unmapped IO addresses read as zero
    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i[15:0] == IO_LED_ADDR) begin
            rd_data_o[LED_BITS-1:0] = led_q;
        end else if (rd_addr_i[15:0] == IO_SW_ADDR) begin
            rd_data_o[LED_BITS-1:0] = io_sw_i;
        end
    end

    assign io_led_o = led_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding CPU memory responder: external sync RAM plus IO registers
module mem_responder
    import tron_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic                 req_fetch,
    input  logic [WIDTH-1:0]     req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [WIDTH-1:0]     instruction,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_we,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic [9:0]           io_sw,
    output logic [9:0]           io_led
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             fetch_q, fetch_d;
    logic [1:0]       wait_q, wait_d;

    logic             addr_is_io;
    logic             led_we;
    logic [WIDTH-1:0] io_rdata;
    logic [WIDTH-1:0] read_data;

    assign addr_is_io = is_io_addr(addr_q[15:0]);
    assign led_we     = (state_q == ST_WRITE) && (addr_q[15:0] == IO_LED_ADDR);
    assign read_data  = addr_is_io ? io_rdata : mem_rdata;

    io_regs #(.WIDTH(WIDTH)) u_io_regs (
        .clk         (clk),
        .reset       (reset),
        .led_we_i    (led_we),
        .led_wdata_i (wdata_q[LED_BITS-1:0]),
        .rd_addr_i   (addr_q),
        .io_sw_i     (io_sw),
        .io_led_o    (io_led),
        .rd_data_o   (io_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            instr_q    <= '0;
            fetch_q    <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            instr_q    <= instr_d;
            fetch_q    <= fetch_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        instr_d    = instr_q;
        fetch_d    = fetch_q;
        wait_d     = wait_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // A store wins over a fetch when both are flagged
                    fetch_d = req_fetch & ~req_write;
                    wait_d  = 2'(WAIT_CYCLES);
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (wait_q == 2'd0) begin
                    rsp_data_d = read_data;
                    if (fetch_q) begin
                        instr_d = read_data;
                    end
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_WRITE: begin
                rsp_data_d = '0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The address goes out straight from the request in IDLE so the RAM's registered
    // read data is ready at the end of a zero-wait READ; reset gates the RAM port instantly.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                if (req_valid) begin
                    mem_addr = req_addr[ADDR_BITS-1:0];
                end
            end else begin
                mem_addr = addr_q[ADDR_BITS-1:0];
            end
            if (state_q == ST_WRITE) begin
                mem_wdata = wdata_q;
                mem_we    = ~addr_is_io;
            end
        end
    end

    assign rsp_data    = rsp_data_q;
    assign instruction = instr_q;

endmodule
